pipeline_hazard_sequencer: RTL and testbench

Sequences the 16-bit in-order pipeline around the ID stage. It tracks the destination registers of the instructions in EXE and MEM and raises `hazard_detected` for true data hazards, either RAW or load-use depending on the forwarding mode. It also flushes IF/ID on a taken branch or jump resolved in ID, and squashes the bubble that follows. It drives the ID stage's hazard input, the PC freeze, the IF/ID flush and the ID/EXE bubble insertion, and keeps saturating stall and flush statistics.

---
 rtl/pipeline_hazard_sequencer_pkg.sv | 12 +
 rtl/pipeline_hazard_sequencer_if.sv | 41 ++++
 rtl/pipeline_hazard_sequencer_track.sv | 28 ++
 rtl/pipeline_hazard_sequencer.sv | 108 ++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared constants and FSM encoding for the ID-stage hazard sequencer.
package pipeline_hazard_sequencer_pkg;

  localparam int REG_FILE_ADDR_LEN = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SQUASH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// ID-stage bundle between the pipeline (master) and the hazard sequencer (slave).
interface pipeline_hazard_sequencer_if
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
  parameter int CNT_W      = 16
);

  logic                  forward_en;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  logic                  id_br_taken;
  logic                  id_jump;

  logic                  hazard_detected;
  logic                  pc_freeze;
  logic                  if_id_flush;
  logic                  id_exe_bubble;
  logic                  id_valid;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output forward_en, id_src1, id_src2, id_two_src, id_dest, id_wb_en,
           id_mem_r_en, id_br_taken, id_jump,
    input  hazard_detected, pc_freeze, if_id_flush, id_exe_bubble, id_valid,
           stall_count, flush_count
  );

  modport slave (
    input  forward_en, id_src1, id_src2, id_two_src, id_dest, id_wb_en,
           id_mem_r_en, id_br_taken, id_jump,
    output hazard_detected, pc_freeze, if_id_flush, id_exe_bubble, id_valid,
           stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_sequencer_track.sv
// One tracked pipeline slot: a valid bit plus a payload, cleared to invalid on a bubble.
module hazard_track_stage
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int W = REG_FILE_ADDR_LEN + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      q <= '0;
    end else if (bubble) begin
      v <= 1'b0;
      q <= '0;
    end else begin
      v <= 1'b1;
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Detects RAW/load-use hazards against EXE and MEM, flushes IF/ID on taken control flow,
// and keeps saturating stall/flush statistics.
module pipeline_hazard_sequencer
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
  parameter int CNT_W      = 16,
  parameter bit R0_ZERO    = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_hazard_sequencer_if.slave  hz
);

  seq_state_t            state_q, state_d;
  logic                  forward_en;
  logic                  id_valid, hazard, flush, bubble;

  logic                  exe_v, exe_wb, exe_mem_r;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic [REG_ADDR_W+1:0] exe_q;
  logic                  mem_v, mem_wb;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [REG_ADDR_W:0]   mem_q;

  logic [CNT_W-1:0]      stall_q, flush_q;

  assign forward_en = hz.forward_en;

  hazard_track_stage #(.W(REG_ADDR_W + 2)) u_exe (
    .clk    (clk),
    .rst    (rst),
    .bubble (bubble),
    .d      ({hz.id_dest, hz.id_wb_en, hz.id_mem_r_en}),
    .v      (exe_v),
    .q      (exe_q)
  );

  // MEM never needs the load flag: load-use is resolved entirely against EXE.
  hazard_track_stage #(.W(REG_ADDR_W + 1)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (!exe_v),
    .d      ({exe_dest, exe_wb}),
    .v      (mem_v),
    .q      (mem_q)
  );

  assign {exe_dest, exe_wb, exe_mem_r} = exe_q;
  assign {mem_dest, mem_wb}            = mem_q;

  function automatic logic match(input logic [REG_ADDR_W-1:0] src);
    logic exe_hit, mem_hit;
    exe_hit = exe_v && (exe_dest == src) && !(R0_ZERO && (exe_dest == '0));
    mem_hit = mem_v && (mem_dest == src) && !(R0_ZERO && (mem_dest == '0));
    if (forward_en)
      return exe_hit && exe_mem_r;
    else
      return (exe_hit && exe_wb) || (mem_hit && mem_wb);
  endfunction

  // Outputs are gated by reset so they drop the instant rst falls.
  always_comb begin
    state_d  = state_q;
    id_valid = 1'b0;
    hazard   = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    if (rst) begin
      id_valid = (state_q != SQUASH);
      hazard   = id_valid && (match(hz.id_src1) || (hz.id_two_src && match(hz.id_src2)));
      flush    = id_valid && !hazard && (hz.id_br_taken || hz.id_jump);
      bubble   = hazard || !id_valid;
      case (state_q)
        RUN, STALL: begin
          if (flush)       state_d = SQUASH;
          else if (hazard) state_d = STALL;
          else             state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush && (flush_q != '1))  flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.hazard_detected = hazard;
  assign hz.pc_freeze       = hazard;
  assign hz.if_id_flush     = flush;
  assign hz.id_exe_bubble   = bubble;
  assign hz.id_valid        = id_valid;
  assign hz.stall_count     = stall_q;
  assign hz.flush_count     = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed scoreboard bench: each applied ID vector pushes its hand-computed response,
// and a monitor compares it against both a 16-bit-counter DUT and a 3-bit-counter DUT.
module tb_pipeline_hazard_sequencer;

  typedef struct {
    int   idx;
    logic haz, flush, bub, valid;
    int   scnt, fcnt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  pipeline_hazard_sequencer_if #(.REG_ADDR_W(4), .CNT_W(16)) hz ();
  pipeline_hazard_sequencer_if #(.REG_ADDR_W(4), .CNT_W(3))  hz_s ();

  pipeline_hazard_sequencer #(.REG_ADDR_W(4), .CNT_W(16), .R0_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // Small-counter copy sees identical stimulus; it exists to reach saturation quickly.
  pipeline_hazard_sequencer #(.REG_ADDR_W(4), .CNT_W(3), .R0_ZERO(1'b1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .hz  (hz_s)
  );

  assign hz_s.forward_en  = hz.forward_en;
  assign hz_s.id_src1     = hz.id_src1;
  assign hz_s.id_src2     = hz.id_src2;
  assign hz_s.id_two_src  = hz.id_two_src;
  assign hz_s.id_dest     = hz.id_dest;
  assign hz_s.id_wb_en    = hz.id_wb_en;
  assign hz_s.id_mem_r_en = hz.id_mem_r_en;
  assign hz_s.id_br_taken = hz.id_br_taken;
  assign hz_s.id_jump     = hz.id_jump;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(
    input logic r, fwd, input logic [3:0] s1, s2, input logic two,
    input logic [3:0] d, input logic wb, mr, br, j,
    input logic e_haz, e_fl, e_bub, e_val, input int e_sc, e_fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    hz.forward_en  = fwd;
    hz.id_src1     = s1;
    hz.id_src2     = s2;
    hz.id_two_src  = two;
    hz.id_dest     = d;
    hz.id_wb_en    = wb;
    hz.id_mem_r_en = mr;
    hz.id_br_taken = br;
    hz.id_jump     = j;
    e.idx = vec_no; e.haz = e_haz; e.flush = e_fl; e.bub = e_bub; e.valid = e_val;
    e.scnt = e_sc; e.fcnt = e_fc;
    exp_q.push_back(e);
    vec_no++;
  endtask

  task automatic check_output(input string name, input int idx, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %0d, expected %0d", name, idx, actual, required);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("hazard_detected", e.idx, int'(hz.hazard_detected), int'(e.haz));
        check_output("pc_freeze",       e.idx, int'(hz.pc_freeze),       int'(e.haz));
        check_output("if_id_flush",     e.idx, int'(hz.if_id_flush),     int'(e.flush));
        check_output("id_exe_bubble",   e.idx, int'(hz.id_exe_bubble),   int'(e.bub));
        check_output("id_valid",        e.idx, int'(hz.id_valid),        int'(e.valid));
        check_output("stall_count",     e.idx, int'(hz.stall_count),     e.scnt);
        check_output("flush_count",     e.idx, int'(hz.flush_count),     e.fcnt);
        check_output("stall_count_sat", e.idx, int'(hz_s.stall_count),   (e.scnt > 7) ? 7 : e.scnt);
      end
    end
  end

  initial begin : driver
    int waited;
    rst = 1'b0;
    hz.forward_en = 0; hz.id_src1 = 0; hz.id_src2 = 0; hz.id_two_src = 0; hz.id_dest = 0;
    hz.id_wb_en = 0; hz.id_mem_r_en = 0; hz.id_br_taken = 0; hz.id_jump = 0;
    $display("[TB] starting directed hazard sequence");

    //             rst fwd s1 s2 two d wb mr br j   haz fl bub val  sc fc
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0); // in reset
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0); // first cycle after release
    // RAW without forwarding, dependent in EXE: two stalls
    apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 1,  0, 0);
    apply_stimulus(1, 0, 3, 0, 0, 4, 1, 0, 0, 0,  1, 0, 1, 1,  0, 0);
    apply_stimulus(1, 0, 3, 0, 0, 4, 1, 0, 0, 0,  1, 0, 1, 1,  1, 0);
    apply_stimulus(1, 0, 3, 0, 0, 4, 1, 0, 0, 0,  0, 0, 0, 1,  2, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  2, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  2, 0);
    // dependent in MEM via src2: one stall
    apply_stimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 0, 0, 1,  2, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  2, 0);
    apply_stimulus(1, 0, 0, 6, 1, 0, 0, 0, 0, 0,  1, 0, 1, 1,  2, 0);
    apply_stimulus(1, 0, 0, 6, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    // src2 matches but is not read
    apply_stimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    apply_stimulus(1, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    // writer of R0 never stalls a reader of R0
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  3, 0);
    // forwarding: load-use stalls once, ALU producer not at all
    apply_stimulus(1, 1, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 0, 1,  3, 0);
    apply_stimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1,  3, 0);
    apply_stimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  4, 0);
    apply_stimulus(1, 1, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 1,  4, 0);
    apply_stimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  4, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  4, 0);
    // taken branch, then squash cycle that ignores a branch+jump on its inputs
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1,  4, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0,  4, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  4, 1);
    // branch and jump together count as one flush; then a lone jump
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 1,  4, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  4, 2);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1,  4, 2);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  4, 3);
    // branch depending on EXE result: flush waits for the hazard to clear
    apply_stimulus(1, 0, 0, 0, 0, 8, 1, 0, 0, 0,  0, 0, 0, 1,  4, 3);
    apply_stimulus(1, 0, 8, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 1,  4, 3);
    apply_stimulus(1, 0, 8, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 1,  5, 3);
    apply_stimulus(1, 0, 8, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1,  6, 3);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  6, 4);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  6, 4);
    // two more stalls push the 3-bit counter past its maximum
    apply_stimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 1,  6, 4);
    apply_stimulus(1, 0, 9, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1,  6, 4);
    apply_stimulus(1, 0, 9, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1,  7, 4);
    apply_stimulus(1, 0, 9, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  8, 4);
    // reset asserted in the middle of a stall, then released
    apply_stimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 1,  8, 4);
    apply_stimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1,  8, 4);
    apply_stimulus(0, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
    apply_stimulus(1, 0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
